mux_scanner: RTL and testbench

MUX_SCANNER -- requirements
Module: mux_scanner

---
 rtl/mux_scanner.sv | 136 +++++++++++++
 tb/tb_mux_scanner.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scanner.sv
// Scans a downstream 4x1 multiplexer: steps the select through 0..3, lets each
// channel settle for DWELL cycles, samples it, and publishes the 4-bit word atomically.
module mux_scanner #(
    parameter int unsigned DWELL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic       abort,
    input  logic       o_in,
    output logic [1:0] s,
    output logic [3:0] q,
    output logic       valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    // With no settle time every channel goes straight to its sample cycle.
    localparam logic [3:0] DWELL_LAST  = (DWELL == 0) ? 4'd0 : 4'(DWELL - 1);
    localparam state_t     FIRST_STATE = (DWELL == 0) ? ST_SAMPLE : ST_SETTLE;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_s;
    logic [1:0] w_s_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [3:0] r_shadow;
    logic [3:0] w_shadow_nxt;
    logic [3:0] r_q;
    logic [3:0] w_q_nxt;
    logic       r_valid;
    logic       w_valid_nxt;
    logic       r_busy;
    logic       w_busy_nxt;

    // State and datapath registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_s      <= 2'd0;
            r_cnt    <= 4'd0;
            r_shadow <= 4'd0;
            r_q      <= 4'd0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_s      <= w_s_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shadow <= w_shadow_nxt;
            r_q      <= w_q_nxt;
            r_valid  <= w_valid_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    // Next-state and datapath decisions; abort outranks settling and sampling.
    always_comb begin
        w_state_nxt  = r_state;
        w_s_nxt      = r_s;
        w_cnt_nxt    = r_cnt;
        w_shadow_nxt = r_shadow;
        w_q_nxt      = r_q;
        w_valid_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = FIRST_STATE;
                    w_s_nxt     = 2'd0;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_s_nxt     = 2'd0;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                    if (r_cnt == DWELL_LAST) begin
                        w_state_nxt = ST_SAMPLE;
                    end else begin
                        w_state_nxt = ST_SETTLE;
                    end
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_s_nxt     = 2'd0;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_shadow_nxt[r_s] = o_in;
                    w_cnt_nxt         = 4'd0;
                    if (r_s == 2'd3) begin
                        // Channel 3 goes straight to q so the word lands in one edge.
                        w_q_nxt     = {o_in, r_shadow[2:0]};
                        w_valid_nxt = 1'b1;
                        w_s_nxt     = 2'd0;
                        if (cont) begin
                            w_state_nxt = FIRST_STATE;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_s_nxt     = r_s + 2'd1;
                        w_state_nxt = FIRST_STATE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_s_nxt     = 2'd0;
                w_cnt_nxt   = 4'd0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign s     = r_s;
    assign q     = r_q;
    assign valid = r_valid;
    assign busy  = r_busy;

endmodule

// File: tb/tb_mux_scanner.sv
// Directed bench for mux_scanner: two instances (DWELL=1 and DWELL=0), each
// driving a modelled 4x1 mux o_in = d[s]; expected values are hand-computed.
module tb_mux_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       cont;
    logic       abort;
    logic       start1;
    logic       start0;
    logic [3:0] d1;
    logic [3:0] d0;
    logic       o_in1;
    logic       o_in0;
    logic [1:0] s1;
    logic [1:0] s0;
    logic [3:0] q1;
    logic [3:0] q0;
    logic       valid1;
    logic       valid0;
    logic       busy1;
    logic       busy0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign o_in1 = d1[s1];
    assign o_in0 = d0[s0];

    mux_scanner #(.DWELL(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start1), .cont(cont), .abort(abort),
        .o_in(o_in1), .s(s1), .q(q1), .valid(valid1), .busy(busy1)
    );

    mux_scanner #(.DWELL(0)) u_d0 (
        .clk(clk), .rst(rst), .start(start0), .cont(cont), .abort(1'b0),
        .o_in(o_in0), .s(s0), .q(q0), .valid(valid0), .busy(busy0)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; cont = 1'b0; abort = 1'b0;
        start1 = 1'b0; start0 = 1'b0; d1 = 4'd0; d0 = 4'd0;

        // reset state, before and after clock edges
        #2;
        chk("rst_s", 8'(s1), 8'd0);
        chk("rst_q", 8'(q1), 8'd0);
        chk("rst_valid", 8'(valid1), 8'd0);
        chk("rst_busy", 8'(busy1), 8'd0);
        tick();
        tick();
        chk("rst_busy_clk", 8'(busy1), 8'd0);
        chk("rst_q0", 8'(q0), 8'd0);

        // scenario 1: DWELL=1, d=1010, start accepted on first edge after release
        rst = 1'b0;
        d1 = 4'b1010;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("s1_busy_e0", 8'(busy1), 8'd1);
        chk("s1_s_e0", 8'(s1), 8'd0);
        for (int j = 1; j < 8; j++) begin
            tick();
            chk("s1_sel", 8'(s1), 8'(j / 2));
            chk("s1_novalid", 8'(valid1), 8'd0);
            chk("s1_busy", 8'(busy1), 8'd1);
        end
        tick();
        chk("s1_valid_e8", 8'(valid1), 8'd1);
        chk("s1_q_e8", 8'(q1), 8'b1010);
        chk("s1_busy_e8", 8'(busy1), 8'd0);
        chk("s1_s_e8", 8'(s1), 8'd0);
        tick();
        chk("s1_valid_e9", 8'(valid1), 8'd0);
        chk("s1_q_e9", 8'(q1), 8'b1010);

        // scenario 2: DWELL=0, d=0110
        d0 = 4'b0110;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("s2_s_e0", 8'(s0), 8'd0);
        chk("s2_busy_e0", 8'(busy0), 8'd1);
        for (int j = 1; j < 4; j++) begin
            tick();
            chk("s2_sel", 8'(s0), 8'(j));
            chk("s2_novalid", 8'(valid0), 8'd0);
        end
        tick();
        chk("s2_valid_e4", 8'(valid0), 8'd1);
        chk("s2_q_e4", 8'(q0), 8'b0110);
        chk("s2_busy_e4", 8'(busy0), 8'd0);
        tick();
        chk("s2_valid_e5", 8'(valid0), 8'd0);

        // scenario 3: continuous scan, cont dropped during the second scan
        d1 = 4'b1100;
        cont = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int j = 1; j < 8; j++) begin
            tick();
            chk("s3_novalid_a", 8'(valid1), 8'd0);
            chk("s3_busy_a", 8'(busy1), 8'd1);
        end
        tick();
        chk("s3_valid_e8", 8'(valid1), 8'd1);
        chk("s3_q_e8", 8'(q1), 8'b1100);
        chk("s3_busy_e8", 8'(busy1), 8'd1);
        chk("s3_s_e8", 8'(s1), 8'd0);
        d1 = 4'b0011;
        cont = 1'b0;
        for (int j = 9; j < 16; j++) begin
            tick();
            chk("s3_novalid_b", 8'(valid1), 8'd0);
            chk("s3_busy_b", 8'(busy1), 8'd1);
            chk("s3_q_hold", 8'(q1), 8'b1100);
        end
        tick();
        chk("s3_valid_e16", 8'(valid1), 8'd1);
        chk("s3_q_e16", 8'(q1), 8'b0011);
        chk("s3_busy_e16", 8'(busy1), 8'd0);

        // scenario 4: start re-pulsed while busy is ignored and not queued
        d1 = 4'b0101;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            start1 = (j == 2 || j == 5);
            tick();
            start1 = 1'b0;
            chk("s4_valid", 8'(valid1), 8'(j == 8));
            chk("s4_busy", 8'(busy1), 8'(j < 8));
        end
        chk("s4_q", 8'(q1), 8'b0101);

        // scenario 5: asynchronous reset mid-cycle between edges 5 and 6
        d1 = 4'b1111;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int j = 1; j <= 5; j++) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("s5_rst_s", 8'(s1), 8'd0);
        chk("s5_rst_busy", 8'(busy1), 8'd0);
        chk("s5_rst_q", 8'(q1), 8'd0);
        chk("s5_rst_valid", 8'(valid1), 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("s5_post_valid", 8'(valid1), 8'd0);
        chk("s5_post_busy", 8'(busy1), 8'd0);
        d1 = 4'b1001;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("s5_restart_busy", 8'(busy1), 8'd1);
        repeat (7) tick();
        chk("s5_novalid_e7", 8'(valid1), 8'd0);
        tick();
        chk("s5_valid_e8", 8'(valid1), 8'd1);
        chk("s5_q_e8", 8'(q1), 8'b1001);

        // scenario 6: abort with prior q=1010
        d1 = 4'b1010;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (8) tick();
        chk("s6_prior_q", 8'(q1), 8'b1010);
        tick();
        d1 = 4'b0101;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("s6_abort_busy", 8'(busy1), 8'd0);
        chk("s6_abort_s", 8'(s1), 8'd0);
        chk("s6_abort_q", 8'(q1), 8'b1010);
        chk("s6_abort_valid", 8'(valid1), 8'd0);
        for (int j = 0; j < 6; j++) begin
            tick();
            chk("s6_idle_valid", 8'(valid1), 8'd0);
            chk("s6_idle_busy", 8'(busy1), 8'd0);
        end

        // abort on the final sample edge wins over publishing
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (7) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("s7_final_abort_valid", 8'(valid1), 8'd0);
        chk("s7_final_abort_q", 8'(q1), 8'b1010);
        chk("s7_final_abort_busy", 8'(busy1), 8'd0);

        // abort together with start in IDLE stays IDLE
        abort = 1'b1;
        start1 = 1'b1;
        tick();
        abort = 1'b0;
        start1 = 1'b0;
        chk("s8_abort_start_busy", 8'(busy1), 8'd0);
        tick();
        chk("s8_abort_start_busy2", 8'(busy1), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
